// File: rtl/mdio_pkg.sv
// mdio_pkg: frame states, opcodes and field widths shared by the Clause-22 MDIO slave.
package mdio_pkg;
    typedef enum logic [3:0] {
        IDLE,
        ST,
        OP,
        PHYAD,
        REGAD,
        WR_TA,
        WR_DATA,
        RD,
        IGNORE
    } state_t;

    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam int OP_W = 2;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
    localparam int TA_W = 2;
    localparam int TAIL_LEN = 18;
endpackage

// File: rtl/mdio_edge_sync.sv
// mdio_edge_sync: synchronizes the MDC/MDIO pads into clk_200m and yields one-cycle
// mdc_rise/mdc_fall pulses with the matching mdio sample.
module mdio_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_200m,
    input  logic rstn_200m,
    input  logic mdc,
    input  logic mdio_in,
    output logic mdio_sync,
    output logic mdc_rise,
    output logic mdc_fall
);
    logic [SYNC_STAGES-1:0] mdc_q;
    logic [SYNC_STAGES-1:0] mdio_q;
    logic mdc_d;

    always_ff @(posedge clk_200m or negedge rstn_200m) begin
        if (!rstn_200m) begin
            mdc_q     <= '0;
            mdio_q    <= '0;
            mdc_d     <= 1'b0;
            mdio_sync <= 1'b0;
            mdc_rise  <= 1'b0;
            mdc_fall  <= 1'b0;
        end else begin
            mdc_q     <= {mdc_q[SYNC_STAGES-2:0], mdc};
            mdio_q    <= {mdio_q[SYNC_STAGES-2:0], mdio_in};
            mdc_d     <= mdc_q[SYNC_STAGES-1];
            mdio_sync <= mdio_q[SYNC_STAGES-1];
            mdc_rise  <= mdc_q[SYNC_STAGES-1] & ~mdc_d;
            mdc_fall  <= ~mdc_q[SYNC_STAGES-1] & mdc_d;
        end
    end
endmodule

// File: rtl/mdio_slave.sv
// mdio_slave: Clause-22 MDIO management target issuing register read/write strobes.
// MDIO_PRE_SUPPRESS_EN: after a completed frame to this PHY, one idle '1' suffices as preamble.
module mdio_slave
    import mdio_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PHY_ADDR = 5'd0,
    parameter int PREAMBLE_LEN = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_200m,
    input  logic              rstn_200m,
    input  logic              mdc,
    input  logic              mdio_in,
    output logic              mdio_out,
    output logic              mdio_oen,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdata
);
    localparam int PW = $clog2(PREAMBLE_LEN + 1);

    state_t state_q, state_n;
    logic mdio_s, rise, fall, ev, last_hdr, hdr_ok, is_rd, wr_done, rd_done, rd_q, pre_ok;
    logic [4:0] cnt;
    logic [PW-1:0] pre_cnt;
    logic [DATA_W-2:0] rx_shift;
    logic [DATA_W-1:0] shift_n, tx_shift;

    mdio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_200m (clk_200m),
        .rstn_200m(rstn_200m),
        .mdc      (mdc),
        .mdio_in  (mdio_in),
        .mdio_sync(mdio_s),
        .mdc_rise (rise),
        .mdc_fall (fall)
    );

    // Every sampled bit is shifted in; at the last REGAD bit the low 12 bits are OP/PHYAD/REGAD.
    assign shift_n  = {rx_shift, mdio_s};
    assign ev       = (state_q == RD) ? fall : rise;
    assign last_hdr = rise && state_q == REGAD && cnt == 5'(ADDR_W - 1);
    assign is_rd    = shift_n[11:10] == OP_RD;
    assign hdr_ok   = (is_rd || shift_n[11:10] == OP_WR) && shift_n[9:5] == PHY_ADDR;
    assign wr_done  = rise && state_q == WR_DATA && cnt == 5'(DATA_W - 1);
    assign rd_done  = fall && state_q == RD && cnt == 5'(TAIL_LEN);

`ifdef MDIO_PRE_SUPPRESS_EN
    logic pre_seen;
    always_ff @(posedge clk_200m or negedge rstn_200m) begin
        if (!rstn_200m) pre_seen <= 1'b0;
        else if (wr_done || rd_done) pre_seen <= 1'b1;
    end
    assign pre_ok = pre_cnt == PW'(PREAMBLE_LEN) || (pre_seen && pre_cnt != '0);
`else
    assign pre_ok = pre_cnt == PW'(PREAMBLE_LEN);
`endif

    always_ff @(posedge clk_200m or negedge rstn_200m) begin
        if (!rstn_200m) state_q <= IDLE;
        else state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (rise && !mdio_s && pre_ok) state_n = ST;
            ST:      if (rise) state_n = mdio_s ? OP : IDLE;
            OP:      if (rise && cnt == 5'(OP_W - 1)) state_n = PHYAD;
            PHYAD:   if (rise && cnt == 5'(ADDR_W - 1)) state_n = REGAD;
            REGAD:   if (last_hdr) state_n = !hdr_ok ? IGNORE : (is_rd ? RD : WR_TA);
            WR_TA:   if (rise && cnt == 5'(TA_W - 1)) state_n = WR_DATA;
            WR_DATA: if (wr_done) state_n = IDLE;
            RD:      if (rd_done) state_n = IDLE;
            IGNORE:  if (rise && cnt == 5'(TAIL_LEN - 1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_200m or negedge rstn_200m) begin
        if (!rstn_200m) begin
            mdio_out  <= 1'b0;
            mdio_oen  <= 1'b1;
            reg_addr  <= '0;
            reg_wr    <= 1'b0;
            reg_wdata <= '0;
            reg_rd    <= 1'b0;
            rd_q      <= 1'b0;
            cnt       <= '0;
            pre_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
        end else begin
            reg_wr <= wr_done;
            reg_rd <= last_hdr && hdr_ok && is_rd;
            rd_q   <= reg_rd;
            if (rise) rx_shift <= shift_n[DATA_W-2:0];
            if (ev) cnt <= (state_n != state_q) ? 5'd0 : cnt + 5'd1;
            if (state_q != IDLE) pre_cnt <= '0;
            else if (rise) pre_cnt <= !mdio_s ? '0 : (pre_cnt == PW'(PREAMBLE_LEN) ? pre_cnt : pre_cnt + PW'(1));
            if (last_hdr && hdr_ok) reg_addr <= shift_n[ADDR_W-1:0];
            if (wr_done) reg_wdata <= shift_n;
            // cnt holds the number of falls already seen in RD: 1 -> TA2, 2..17 -> D15..D0, 18 -> release.
            if (rd_q) tx_shift <= reg_rdata;
            else if (fall && state_q == RD && cnt >= 5'd2 && cnt <= 5'd17) tx_shift <= tx_shift << 1;
            if (fall && state_q == RD) begin
                if (cnt == 5'd1) begin
                    mdio_oen <= 1'b0;
                    mdio_out <= 1'b0;
                end else if (cnt == 5'(TAIL_LEN)) begin
                    mdio_oen <= 1'b1;
                    mdio_out <= 1'b0;
                end else if (cnt >= 5'd2) begin
                    mdio_out <= tx_shift[DATA_W-1];
                end
            end
        end
    end
endmodule

// File: doc/mdio_slave.md
Name: mdio_slave

Overview:
- Clause-22 MDIO slave (management target) on the clk_200m domain. Decodes frames arriving on the MDC/MDIO pads and drives the shared MDIO line through mdio_out/mdio_oen.
- Issues single-cycle register read/write strobes to the digital config register file that produces the rf_* controls (capture, 96-path enable, pktctrl gap/phase, mdio data select/memory address).
- Sits between the iopad MDC/MDIO nets and the register bank inside ctrl_sys.

Parameters:
- PHY_ADDR, 5'd0, PHY address this slave answers to.
- PREAMBLE_LEN, 32, consecutive '1' bits required before ST.
- SYNC_STAGES, 2, synchronizer depth for mdc and mdio_in (>=2).

Ports:
- clk_200m  in  1  system clock, 200 MHz.
- rstn_200m  in  1  asynchronous active-low reset.
- mdc  in  1  MDIO clock from pad, asynchronous to clk_200m.
- mdio_in  in  1  MDIO data from pad.
- mdio_out  out  1  MDIO data to pad.
- mdio_oen  out  1  pad output enable, active-low (0 = drive).
- reg_addr  out  5  REGAD of the current frame.
- reg_wr  out  1  one-cycle write strobe.
- reg_wdata  out  16  write data, valid while reg_wr=1.
- reg_rd  out  1  one-cycle read strobe.
- reg_rdata  in  16  read data, valid the cycle after reg_rd.

Behaviour:
- Reset values: mdio_out=0, mdio_oen=1, reg_wr=0, reg_rd=0, reg_addr=0, reg_wdata=0. State=IDLE, preamble count=0, shift registers=0.
- mdc and mdio_in each pass through SYNC_STAGES flops. Edge detect on synchronized mdc gives mdc_rise (sample) and mdc_fall (drive). Each is a one-cycle pulse, SYNC_STAGES+1 cycles after the pad edge.
- Timing constraint: MDC high and low phases >= 4 clk_200m cycles each (MDC <= 25 MHz). Faster MDC is unsupported.
- All field decoding below happens on mdc_rise, sampling mdio_sync, MSB first.
- IDLE:
  - mdio=1: pre_cnt increments, saturating at PREAMBLE_LEN.
  - mdio=0 with pre_cnt==PREAMBLE_LEN: go to ST.
  - mdio=0 otherwise: pre_cnt=0.
- ST: mdio=1 goes to OP. mdio=0 goes to IDLE with pre_cnt=0.
- OP: 2 bits; 2'b10 = read, 2'b01 = write. Then PHYAD (5 bits), then REGAD (5 bits).
  - On the last REGAD rise: if opcode is invalid or PHYAD != PHY_ADDR, go to IGNORE. Otherwise reg_addr <= REGAD.
- IGNORE: count 18 more rising edges, then IDLE. No strobes. mdio_oen stays 1.
- WRITE:
  - Enter WR_TA. Two TA bits are sampled and not checked.
  - WR_DATA: 16 bits shifted in.
  - On the 16th data rise, reg_wdata<=shift and reg_wr=1 for exactly one clk_200m cycle. Then IDLE.
- READ:
  - On the last REGAD rise, reg_rd=1 for one cycle. On the next cycle, reg_rdata is latched into the 16-bit tx shift register.
  - Falling edges are counted after the last REGAD rise:
    - fall #1 (TA1): oen stays 1.
    - fall #2 (TA2): oen=0, out=0.
    - falls #3..#18: out = D15..D0.
    - fall #19: oen=1, out=0, go to IDLE.
- On return to IDLE from any frame, pre_cnt=0. A fresh full preamble is required, except under the optional feature below.
- reg_wr and reg_rd are never asserted in the same cycle. At most one strobe per frame.
- MDC stalling mid-frame: state is held indefinitely; no timeout.
- Reset asserted mid-frame: asynchronous return to reset values; mdio_oen=1 immediately. The next frame needs a full preamble.

Optional Feature:
- Macro: MDIO_PRE_SUPPRESS_EN.
- Defined:
  - A sticky flag sets once any frame addressed to PHY_ADDR completes.
  - While the flag is set, IDLE accepts ST after >=1 idle '1' bit, instead of PREAMBLE_LEN bits.
  - The flag is cleared only by reset.
- Undefined: a full preamble is always required; the flag logic is absent.

Decomposition:
- Package mdio_pkg:
  - state enum IDLE/ST/OP/PHYAD/REGAD/WR_TA/WR_DATA/RD/IGNORE.
  - Constants OP_RD=2'b10, OP_WR=2'b01, field widths (OP=2, ADDR=5, DATA=16, TA=2), frame tail length 18.
- Sub-module mdio_edge_sync: SYNC_STAGES synchronizers for mdc/mdio_in, plus mdc_rise/mdc_fall generation.

Test Plan:
- Write: 32x'1', ST, OP=01, PHYAD=0, REGAD=5'h03, TA, data 16'hA5C3 -> exactly one reg_wr pulse with reg_addr=5'h03, reg_wdata=16'hA5C3; mdio_oen=1 throughout.
- Read: REGAD=5'h07, reg_rdata=16'h1234 -> one reg_rd pulse; oen=0 from TA2 through D0; pad bits sampled on MDC rise are 0, then 16'h1234 MSB first; oen=1 after fall #19.
- PHYAD=5'h1F with PHY_ADDR=0 -> no reg_rd/reg_wr pulse, oen=1 for the whole frame, next valid frame accepted.
- 31-bit preamble before ST -> frame ignored, no strobes; retry with 32 bits succeeds.
- rstn_200m low during D8 of a read -> oen=1 and out=0 at once; after release, a full read of 5'h07 returns correct data.
- Back-to-back write frames with 1 idle bit between -> second frame is accepted with MDIO_PRE_SUPPRESS_EN, and ignored (no reg_wr) without it.
